serial_word_rx: RTL and testbench
=================================

# serial_word_rx

Parametrised serial-to-parallel receiver clocked on the inverted serial clock. It shifts `ser_in` into a WIDTH-bit register under `enable` and counts bits to frame complete words. Each completed word is transferred to a holding register with a valid/acknowledge handshake and overrun detection. It sits behind the serial write engine: that engine drives `serclk`, `ser_in`, `enable` and `sync`, and the host side consumes `data`.

## Interface
- WIDTH, 8: data bits per word, 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in `data[WIDTH-1]`; 0 = first bit lands in `data[0]`.

- inv_serclk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high.
- ser_in  input  1  serial data bit.
- enable  input  1  active high; bit on `ser_in` is taken this edge.
- sync  input  1  active high; restarts word framing (bit counter to 0).
- rd_ack  input  1  consumer acknowledge; clears `word_valid`.
- shift_q  output  WIDTH  live shift register contents.
- data  output  WIDTH  holding register, last completed word.
- word_valid  output  1  `data` holds an unacknowledged word.
- overrun  output  1  sticky: a word completed while `word_valid` was still set.
- parity_err  output  1  parity result of the word in `data`; constant 0 without SERIAL_WORD_RX_PARITY_EN.

## Operation
- Reset, asynchronous, any time including mid-word, clears:
  - shift_q, data and bit counter to 0.
  - word_valid, overrun and parity_err to 0.
- Frame length:
  - L = WIDTH without SERIAL_WORD_RX_PARITY_EN.
  - L = WIDTH+1 with it; the final bit is the parity bit.
- Bit counter: $clog2(L+1) bits, range 0..L-1.
- Edge with enable=1, data bit (count < WIDTH):
  - MSB_FIRST=1: shift_q <= {shift_q[WIDTH-2:0], ser_in}.
  - MSB_FIRST=0: shift_q <= {ser_in, shift_q[WIDTH-1:1]}.
  - count increments.
- Edge with enable=1, count = L-1 (word complete):
  - data <= fully assembled word, including the bit on this edge.
  - word_valid <= 1; count <= 0.
- Edge with enable=0: no state change except the rd_ack and sync effects.
- sync=1 clears count before the bit is considered.
  - With enable=1 on the same edge, the bit becomes bit 0 of a new word (count=1).
  - shift_q is not cleared.
- rd_ack=1 with word_valid=1 clears word_valid. rd_ack with word_valid=0 is ignored.
- Word completes while word_valid=1 and rd_ack=0:
  - data is overwritten with the new word.
  - overrun <= 1; it stays set until reset.
- Word completes on the same edge as rd_ack=1: data is loaded, word_valid stays 1, no overrun.

## Timing
- One bit per enabled edge; no pipeline stall.
- Latency: data and word_valid update on the same edge that captures the last bit of the frame. They are visible to the consumer on the next edge.
- word_valid falls one edge after rd_ack is sampled.
- Back-to-back words with no gap are supported. Maximum word rate is one word every L enabled edges.

## Configuration
- SERIAL_WORD_RX_PARITY_EN defined:
  - Each frame carries one trailing even-parity bit (bit L-1).
  - The parity bit is not shifted into shift_q.
  - parity_err <= (XOR of the data bits) ^ parity bit, loaded together with data.
- SERIAL_WORD_RX_PARITY_EN undefined:
  - Frames are WIDTH bits long.
  - parity_err is tied to 0; no parity logic is synthesised.

## Structure
- Shared package serial_pkg:
  - default WIDTH constant.
  - counter-width function clog2.
  - MSB_FIRST encoding constants.
- Sub-module serial_shift_core:
  - Contents: WIDTH/MSB_FIRST shift register plus enable.
  - Top level keeps the bit counter, holding register, handshake and parity.

## Test plan
- WIDTH=8, MSB_FIRST=1, 8 enabled bits 1,0,1,0,0,1,0,1 -> data=8'hA5, word_valid=1 after the 8th edge; shift_q=8'hA5.
- MSB_FIRST=0, same bit order -> data=8'hA5 reversed = 8'hA5 (palindrome); then 1,1,0,0,0,0,0,0 -> data=8'h03.
- Two back-to-back words 8'h12, 8'h34 with no rd_ack -> data=8'h34, overrun=1; repeat with rd_ack on the 16th edge -> overrun=0, word_valid=1.
- Assert reset after 5 bits, release, send 8'hFF -> data=8'hFF; no stale bits, count restarts at 0.
- Send 3 bits, sync with enable on the 4th edge, 7 more bits -> word completes on the 11th edge, not the 8th.
- Parity enabled, send 8'h01 + parity 1 -> parity_err=0; send 8'h01 + parity 0 -> parity_err=1.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared constants and helpers for the serial receive path.
package serial_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int LSB_FIRST_ORDER = 0;
    localparam int MSB_FIRST_ORDER = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/serial_shift_core.sv
// serial_shift_core: WIDTH-bit shift register, direction set by MSB_FIRST.
module serial_shift_core
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = MSB_FIRST_ORDER
) (
    input  logic             inv_serclk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] shift_q,
    output logic [WIDTH-1:0] shift_d
);

    // shift_d is the value the register takes this edge, so the top can latch a word including the current bit
    always_comb
        shift_d = !shift_en ? shift_q :
                  (MSB_FIRST == MSB_FIRST_ORDER) ? {shift_q[WIDTH-2:0], ser_in} :
                                                    {ser_in, shift_q[WIDTH-1:1]};

    always_ff @(posedge inv_serclk or posedge reset)
        if (reset) shift_q <= '0;
        else       shift_q <= shift_d;

endmodule

// File: rtl/serial_word_rx.sv
// serial_word_rx: serial-to-parallel word receiver with valid/ack handshake and overrun flag.
// Define SERIAL_WORD_RX_PARITY_EN to append a trailing even-parity bit to every frame.
module serial_word_rx
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = MSB_FIRST_ORDER
) (
    input  logic             inv_serclk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             enable,
    input  logic             sync,
    input  logic             rd_ack,
    output logic [WIDTH-1:0] shift_q,
    output logic [WIDTH-1:0] data,
    output logic             word_valid,
    output logic             overrun,
    output logic             parity_err
);

`ifdef SERIAL_WORD_RX_PARITY_EN
    localparam int L = WIDTH + 1;
`else
    localparam int L = WIDTH;
`endif
    localparam int CW = clog2(L + 1);

    logic [CW-1:0]    count, count_eff;
    logic [WIDTH-1:0] shift_d;
    logic             shift_en, done;

    // sync restarts framing before the current bit is counted
    always_comb begin
        count_eff = sync ? '0 : count;
        shift_en  = enable && (count_eff < CW'(WIDTH));
        done      = enable && (count_eff == CW'(L - 1));
    end

    serial_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .inv_serclk (inv_serclk),
        .reset      (reset),
        .shift_en   (shift_en),
        .ser_in     (ser_in),
        .shift_q    (shift_q),
        .shift_d    (shift_d)
    );

    always_ff @(posedge inv_serclk or posedge reset)
        if (reset) begin
            count      <= '0;
            data       <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            count      <= done ? '0 : count_eff + CW'(enable);
            if (done) data <= shift_d;
            word_valid <= done | (word_valid & ~rd_ack);
            overrun    <= overrun | (done & word_valid & ~rd_ack);
        end

`ifdef SERIAL_WORD_RX_PARITY_EN
    // the parity bit itself is never shifted in, so shift_q holds exactly the data bits here
    always_ff @(posedge inv_serclk or posedge reset)
        if (reset)     parity_err <= 1'b0;
        else if (done) parity_err <= (^shift_q) ^ ser_in;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx: directed test of serial_word_rx against a queue-based frame model, MSB- and LSB-first instances.
module tb_serial_word_rx;

`ifdef SERIAL_WORD_RX_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk, reset, ser_in, enable, sync, rd_ack;
    logic [7:0] shq_m, dat_m, shq_l, dat_l;
    logic       val_m, ovr_m, per_m, val_l, ovr_l, per_l;

    int n_chk = 0;
    int n_pass = 0;

    serial_word_rx #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
        .inv_serclk (clk), .reset (reset), .ser_in (ser_in), .enable (enable),
        .sync (sync), .rd_ack (rd_ack), .shift_q (shq_m), .data (dat_m),
        .word_valid (val_m), .overrun (ovr_m), .parity_err (per_m)
    );

    serial_word_rx #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
        .inv_serclk (clk), .reset (reset), .ser_in (ser_in), .enable (enable),
        .sync (sync), .rd_ack (rd_ack), .shift_q (shq_l), .data (dat_l),
        .word_valid (val_l), .overrun (ovr_l), .parity_err (per_l)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // model: frm = bits of the current frame in arrival order, hist = last 8 data bits since reset
    bit         frm[$];
    bit         hist[$];
    logic [7:0] m_first;
    logic       m_valid, m_ovr, m_perr;

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    function automatic logic [7:0] recent();
        logic [7:0] r;
        int n;
        r = '0;
        n = hist.size();
        for (int i = 0; i < n; i++) r[i] = hist[n-1-i];
        return r;
    endfunction

    task automatic model_reset();
        frm.delete();
        hist.delete();
        m_first = '0;
        m_valid = 0;
        m_ovr   = 0;
        m_perr  = 0;
    endtask

    task automatic model_step();
        bit done;
        done = 0;
        if (sync) frm.delete();
        if (enable) begin
            if (frm.size() < 8) begin
                hist.push_back(ser_in);
                if (hist.size() > 8) void'(hist.pop_front());
            end
            frm.push_back(ser_in);
            if (frm.size() == FL) begin
                for (int i = 0; i < 8; i++) m_first[i] = frm[i];
                m_perr = 0;
                if (FL == 9) foreach (frm[i]) m_perr ^= frm[i];
                m_ovr   = m_ovr | (m_valid & ~rd_ack);
                m_valid = 1;
                frm.delete();
                done = 1;
            end
        end
        if (!done && rd_ack) m_valid = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // every edge goes through here so the model sees the same inputs the DUTs do
    task automatic step(input logic b, input logic en, input logic sy, input logic ack);
        ser_in = b; enable = en; sync = sy; rd_ack = ack;
        @(posedge clk);
        model_step();
        #1;
        ser_in = 0; enable = 0; sync = 0; rd_ack = 0;
    endtask

    task automatic send_frame(input logic [7:0] w, input logic ack_last);
        for (int i = 7; i >= 0; i--) step(w[i], 1, 0, ack_last && i == 0 && FL == 8);
        if (FL == 9) step(^w, 1, 0, ack_last);
    endtask

    task automatic do_reset();
        reset = 1;
        model_reset();
        #2;
        check("rst shift_q", shq_m, 8'h00);
        check("rst data", dat_m, 8'h00);
        check("rst word_valid", val_m, 1'b0);
        check("rst overrun", ovr_l, 1'b0);
        #5;
        reset = 0;
        step(0, 0, 0, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("msb shift_q", shq_m, recent());
            check("lsb shift_q", shq_l, rev8(recent()));
            check("msb data", dat_m, rev8(m_first));
            check("lsb data", dat_l, m_first);
            check("msb word_valid", val_m, m_valid);
            check("lsb word_valid", val_l, m_valid);
            check("msb overrun", ovr_m, m_ovr);
            check("lsb overrun", ovr_l, m_ovr);
            check("msb parity_err", per_m, m_perr);
            check("lsb parity_err", per_l, m_perr);
        end
    end

    initial begin
        ser_in = 0; enable = 0; sync = 0; rd_ack = 0;
        do_reset();

        send_frame(8'hA5, 0);
        check("A5 msb data", dat_m, 8'hA5);
        check("A5 msb shift_q", shq_m, 8'hA5);
        check("A5 lsb data", dat_l, 8'hA5);
        check("A5 word_valid", val_m, 1'b1);
        step(0, 0, 0, 1);
        check("ack clears valid", val_m, 1'b0);
        send_frame(8'hC0, 0);
        check("C0 lsb data", dat_l, 8'h03);
        check("C0 msb data", dat_m, 8'hC0);
        check("C0 no overrun", ovr_m, 1'b0);

        do_reset();
        send_frame(8'h12, 0);
        send_frame(8'h34, 0);
        check("b2b data", dat_m, 8'h34);
        check("b2b overrun", ovr_m, 1'b1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("overrun sticky", ovr_l, 1'b1);

        do_reset();
        send_frame(8'h12, 0);
        send_frame(8'h34, 1);
        check("b2b ack overrun", ovr_m, 1'b0);
        check("b2b ack valid", val_m, 1'b1);
        check("b2b ack data", dat_m, 8'h34);

        do_reset();
        for (int i = 0; i < 5; i++) step(i[0], 1, 0, 0);
        do_reset();
        send_frame(8'hFF, 0);
        check("FF msb data", dat_m, 8'hFF);
        check("FF lsb data", dat_l, 8'hFF);
        check("FF shift_q", shq_m, 8'hFF);

        do_reset();
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        for (int i = 6; i >= 1; i--) step(8'hB3 >> i, 1, 0, 0);
        check("sync no early word", val_m, 1'b0);
        step(1, 1, 0, 0);
        if (FL == 9) step(^8'hB3, 1, 0, 0);
        check("sync word valid", val_m, 1'b1);
        check("sync msb data", dat_m, 8'hB3);
        check("sync lsb data", dat_l, 8'hCD);

`ifdef SERIAL_WORD_RX_PARITY_EN
        do_reset();
        for (int i = 7; i >= 0; i--) step(i == 0, 1, 0, 0);
        step(1, 1, 0, 0);
        check("parity good", per_m, 1'b0);
        check("parity lsb data", dat_l, 8'h80);
        step(0, 0, 0, 1);
        for (int i = 7; i >= 0; i--) step(i == 0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("parity bad", per_m, 1'b1);
        check("parity bad lsb", per_l, 1'b1);
`endif

        step(0, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
